bnn_inference_scheduler: RTL
============================

Name: bnn_inference_scheduler

Overview:
Shares one BNN inference core among NUM_REQ requesters using round-robin arbitration. For the winning requester it latches the input vector, pulses core_start, and waits for core_done or a watchdog timeout. It then returns the class result to that requester with a one-hot response pulse. It sits between the input sources and the BNN pipeline, and its core_start/core_done pair drives the performance monitor.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 16, binarised input vector width
RES_W, 4, class-index result width
TIMEOUT, 1023, max WAIT cycles before abort (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*DATA_W  packed inputs; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot accept; combinational, (state==IDLE) & grant
core_start  out  1  one-cycle start pulse to the BNN core
core_data  out  DATA_W  latched input; stable from START through RESP
core_done  in  1  core result-valid pulse
core_result  in  RES_W  core class output, sampled on core_done
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the granted requester
rsp_result  out  RES_W  result; held until the next RESP
rsp_timeout  out  1  response came from the watchdog; held like rsp_result
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
timeout_count  out  8  saturating count of timeouts

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; timer=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - grant = first asserted req_valid searching from last_grant+1, wrapping modulo NUM_REQ.
  - If any req_valid: req_ready[grant]=1; latch core_data and grant_id; next state START.
  - If none: req_ready=0; remain in IDLE.
- START: core_start=1 for exactly this one cycle; timer cleared; next state WAIT.
- WAIT: timer increments by 1 per cycle.
  - core_done=1: capture core_result into rsp_result; rsp_timeout<=0; next state RESP.
  - Else if timer==TIMEOUT-1: rsp_result<=0; rsp_timeout<=1; timeout_count+1, saturating at 255; next state RESP.
  - core_done on the same cycle as timer expiry: done wins, no timeout recorded.
- RESP: rsp_valid[grant_id]=1 for one cycle; last_grant<=grant_id; next state IDLE.
- Latency: accept at cycle T; core_start at T+1; core_done at cycle D gives rsp_valid at D+1. Minimum accept-to-response is 3 cycles (done at T+2).
- Request spacing: a new request can be accepted at most every 4 cycles. No back-to-back accepts; IDLE is always visited for one cycle.
- core_done outside WAIT (IDLE, START, RESP) is ignored; no state change, result not captured.
- Request handling:
  - A requester that drops req_valid before ready simply loses its turn; it is not latched.
  - req_data is sampled only in the accept cycle.
- Round-robin fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Reset asserted mid-operation: immediate return to IDLE with outputs cleared. No response is issued for the in-flight request; the core must be reset alongside.
- Width rule: timer width is $clog2(TIMEOUT+1); compares are unsigned.

Decomposition:
- Package bnn_sched_pkg: state enum (IDLE=2'd0, START=2'd1, WAIT=2'd2, RESP=2'd3) and the timeout_count saturation constant (8'hFF).
- Sub-module bnn_rr_arbiter:
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant, grant index and any_req.
  - Purely combinational; instantiated once.

Test Plan:
- Single request: req_valid=4'b0100, data=16'hA5A5; core_done 5 cycles after core_start with result 4'd7 -> req_ready[2] at T, core_start at T+1, core_data=16'hA5A5, rsp_valid=4'b0100, rsp_result=7, rsp_timeout=0.
- Round-robin: all four requesting continuously, core_done 2 cycles after each start -> grant order 0,1,2,3,0; no requester granted twice before others.
- Timeout: TIMEOUT=8, core never responds -> rsp_valid at START+9, rsp_timeout=1, rsp_result=0, timeout_count=1. After 256 timeouts, timeout_count stays 255.
- Done at expiry: core_done on the same cycle timer==TIMEOUT-1, result 4'd3 -> rsp_timeout=0, rsp_result=3, timeout_count unchanged.
- Spurious done: core_done pulsed in IDLE and in START -> no response, state sequence unaffected, rsp_result unchanged.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> busy=0 and all outputs 0 immediately, no rsp_valid; the next request goes to requester 0 first.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
// Shared types and constants for the BNN inference scheduler.
package bnn_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TO_CNT_MAX = 8'hFF;
endpackage

// File: rtl/bnn_rr_arbiter.sv
// Combinational round-robin arbiter: searches from i_last_grant+1, wrapping.
module bnn_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_id,
  output logic               o_any_req
);
  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any_req  = |i_req;
    w_found    = 1'b0;
    w_idx      = 0;
    // Offset NUM_REQ wraps back to the last winner, so it is considered last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = (int'(i_last_grant) + off) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = IDX_W'(w_idx);
      end
    end
  end
endmodule

// File: rtl/bnn_inference_scheduler.sv
// Time-shares one BNN core among NUM_REQ requesters with round-robin
// arbitration and a watchdog on the core's done pulse.
module bnn_inference_scheduler
  import bnn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         core_start,
  output logic [DATA_W-1:0]            core_data,
  input  logic                         core_done,
  input  logic [RES_W-1:0]             core_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [RES_W-1:0]             rsp_result,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [7:0]                   timeout_count
);
  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_last_grant, r_grant_id, w_arb_id;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic               w_any_req;
  logic [TMR_W-1:0]   r_timer;
  logic [DATA_W-1:0]  r_core_data;
  logic [RES_W-1:0]   r_rsp_result;
  logic               r_rsp_timeout;
  logic [7:0]         r_timeout_count;
  logic               w_expire;

  bnn_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_grant_id   (w_arb_id),
    .o_any_req    (w_any_req)
  );

  assign w_expire = (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    core_start   = 1'b0;
    rsp_valid    = '0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        req_ready = w_arb_grant;
        if (w_any_req) w_state_next = START;
      end
      START: begin
        core_start   = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (core_done || w_expire) w_state_next = RESP;
      end
      RESP: begin
        rsp_valid[r_grant_id] = 1'b1;
        w_state_next          = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant    <= IDX_W'(NUM_REQ - 1);
      r_grant_id      <= '0;
      r_timer         <= '0;
      r_core_data     <= '0;
      r_rsp_result    <= '0;
      r_rsp_timeout   <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id  <= w_arb_id;
            r_core_data <= req_data[w_arb_id*DATA_W +: DATA_W];
          end
        end
        START: r_timer <= '0;
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A done pulse on the expiry cycle still counts as a real result.
          if (core_done) begin
            r_rsp_result  <= core_result;
            r_rsp_timeout <= 1'b0;
          end else if (w_expire) begin
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b1;
            if (r_timeout_count != TO_CNT_MAX)
              r_timeout_count <= r_timeout_count + 8'd1;
          end
        end
        RESP: r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  assign core_data     = r_core_data;
  assign rsp_result    = r_rsp_result;
  assign rsp_timeout   = r_rsp_timeout;
  assign grant_id      = r_grant_id;
  assign timeout_count = r_timeout_count;
endmodule
